disp_serial_shifter: RTL and testbench

- Downstream consumer of the 64-bit `Disp_num` word produced by the random block generator.
- Snapshots the word on request and shifts it out MSB-first to the board's serial display chain (74HC595-style shift-register string) using a generated serial clock, then pulses a latch to present the new image.
- Provides `busy`/`done` handshaking so the game logic can pace display refreshes.

---
 rtl/disp_serial_shifter.sv | 164 ++++++++++++++++
 tb/tb_disp_serial_shifter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_serial_shifter.sv
// Serialises a WIDTH-bit display image MSB-first onto a 74HC595-style
// chain: generated shift clock, data, latch strobe and active-low clear.
// A start request snapshots the image; requests arriving mid-frame are
// remembered (one deep) and replayed as soon as the frame finishes.
module disp_serial_shifter #(
    parameter int WIDTH = 64,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Disp_num,
    output logic             seg_clk,
    output logic             seg_sout,
    output logic             seg_latch,
    output logic             seg_clrn,
    output logic             busy,
    output logic             done
);

    localparam int DW = $clog2(DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] shift_left;
    logic [DW-1:0]    div_cnt_reg, div_cnt_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic             pending_reg, pending_next;
    logic             seg_clk_reg, seg_clk_next;
    logic             seg_sout_reg, seg_sout_next;
    logic             seg_latch_reg, seg_latch_next;
    logic             seg_clrn_reg, seg_clrn_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    // Shift register moved one place towards the MSB, zero fill at the bottom.
    assign shift_left[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shl
            assign shift_left[gi] = shift_reg[gi-1];
        end
    endgenerate

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        div_cnt_next   = div_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        pending_next   = pending_reg;
        seg_clk_next   = seg_clk_reg;
        seg_sout_next  = seg_sout_reg;
        seg_latch_next = seg_latch_reg;
        seg_clrn_next  = 1'b1;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start || pending_reg) begin
                    state_next    = SHIFT;
                    shift_next    = Disp_num;
                    seg_sout_next = Disp_num[WIDTH-1];
                    seg_clk_next  = 1'b0;
                    busy_next     = 1'b1;
                    pending_next  = 1'b0;
                    div_cnt_next  = '0;
                    bit_cnt_next  = '0;
                end
            end

            SHIFT: begin
                if (start) begin
                    pending_next = 1'b1;
                end
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    if (!seg_clk_reg) begin
                        // End of the low half: rising edge, data already stable.
                        seg_clk_next = 1'b1;
                    end else begin
                        // End of the high half: falling edge, advance data.
                        seg_clk_next = 1'b0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_next     = LATCH;
                            seg_latch_next = 1'b1;
                        end else begin
                            bit_cnt_next  = bit_cnt_reg + 1'b1;
                            shift_next    = shift_left;
                            seg_sout_next = shift_reg[WIDTH-2];
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end

            LATCH: begin
                if (start) begin
                    pending_next = 1'b1;
                end
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next   = '0;
                    state_next     = IDLE;
                    seg_latch_next = 1'b0;
                    busy_next      = 1'b0;
                    done_next      = 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame and clears the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            pending_reg   <= 1'b0;
            seg_clk_reg   <= 1'b0;
            seg_sout_reg  <= 1'b0;
            seg_latch_reg <= 1'b0;
            seg_clrn_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            div_cnt_reg   <= div_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            pending_reg   <= pending_next;
            seg_clk_reg   <= seg_clk_next;
            seg_sout_reg  <= seg_sout_next;
            seg_latch_reg <= seg_latch_next;
            seg_clrn_reg  <= seg_clrn_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign seg_clk   = seg_clk_reg;
    assign seg_sout  = seg_sout_reg;
    assign seg_latch = seg_latch_reg;
    assign seg_clrn  = seg_clrn_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_disp_serial_shifter.sv
// Bench for disp_serial_shifter: one DIV=2 and one DIV=1 instance, a
// frame-timeline model checked every cycle, plus literal frame checks.
module tb_disp_serial_shifter;

    localparam int W = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [2];
    logic [63:0] disp [2];
    logic        seg_clk [2];
    logic        seg_sout [2];
    logic        seg_latch [2];
    logic        seg_clrn [2];
    logic        busy [2];
    logic        done [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    disp_serial_shifter #(.WIDTH(64), .DIV(2)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .Disp_num(disp[0]),
        .seg_clk(seg_clk[0]), .seg_sout(seg_sout[0]), .seg_latch(seg_latch[0]),
        .seg_clrn(seg_clrn[0]), .busy(busy[0]), .done(done[0])
    );

    disp_serial_shifter #(.WIDTH(64), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .Disp_num(disp[1]),
        .seg_clk(seg_clk[1]), .seg_sout(seg_sout[1]), .seg_latch(seg_latch[1]),
        .seg_clrn(seg_clrn[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int divof(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // ---------------- frame-timeline model ----------------
    // m_k = clock edges since the load edge of the current frame.
    bit          m_valid = 0;
    bit          m_rstd = 0;
    bit          m_act [2] = '{0, 0};
    bit          m_pend [2] = '{0, 0};
    bit          m_done [2] = '{0, 0};
    int          m_k [2] = '{0, 0};
    logic [63:0] m_data [2] = '{64'h0, 64'h0};

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_valid = 1;
            m_rstd  = 1;
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_pend[i] = 0; m_done[i] = 0;
            end
        end else begin
            m_rstd = 0;
            for (int i = 0; i < 2; i++) begin
                int d;
                d = divof(i);
                m_done[i] = 0;
                if (m_act[i]) begin
                    if (start[i]) m_pend[i] = 1;
                    m_k[i]++;
                    if (m_k[i] == W * 2 * d + d) begin
                        m_act[i]  = 0;
                        m_done[i] = 1;
                    end
                end else if (start[i] || m_pend[i]) begin
                    m_act[i]  = 1;
                    m_k[i]    = 0;
                    m_data[i] = disp[i];
                    m_pend[i] = 0;
                end
            end
        end
    end

    // ---------------- per-frame measurements ----------------
    logic [63:0] cap [2] = '{64'h0, 64'h0};
    int rises [2] = '{0, 0};
    int flen [2] = '{0, 0};
    int done_len [2] = '{0, 0};
    int latch_len [2] = '{0, 0};
    int ones [2] = '{0, 0};
    int gap [2] = '{0, 0};
    int last_gap [2] = '{0, 0};
    int frames [2] = '{0, 0};
    int dones [2] = '{0, 0};
    bit prev_busy [2] = '{0, 0};
    bit prev_clk [2] = '{0, 0};

    // Compare against the model and collect frame statistics every cycle.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                int d, t, k;
                logic e_clk, e_latch, e_busy, e_done;
                d = divof(i);
                t = W * 2 * d;
                k = m_k[i];
                if (m_act[i]) begin
                    e_busy = 1'b1;
                    e_done = 1'b0;
                    if (k < t) begin
                        e_clk   = ((k % (2 * d)) >= d);
                        e_latch = 1'b0;
                        chk($sformatf("sout%0d_k%0d", i, k), 64'(seg_sout[i]),
                            64'(m_data[i][W - 1 - k / (2 * d)]));
                    end else begin
                        e_clk   = 1'b0;
                        e_latch = 1'b1;
                    end
                end else begin
                    e_clk = 1'b0; e_latch = 1'b0; e_busy = 1'b0;
                    e_done = m_done[i];
                    if (m_rstd) chk($sformatf("sout%0d_rst", i), 64'(seg_sout[i]), 64'h0);
                end
                chk($sformatf("seg_clk%0d", i),   64'(seg_clk[i]),   64'(e_clk));
                chk($sformatf("seg_latch%0d", i), 64'(seg_latch[i]), 64'(e_latch));
                chk($sformatf("busy%0d", i),      64'(busy[i]),      64'(e_busy));
                chk($sformatf("done%0d", i),      64'(done[i]),      64'(e_done));
                chk($sformatf("seg_clrn%0d", i),  64'(seg_clrn[i]),  64'(!m_rstd));

                if (busy[i] && !prev_busy[i]) begin
                    cap[i] = 64'h0; rises[i] = 0; flen[i] = 0; latch_len[i] = 0;
                    ones[i] = 0; last_gap[i] = gap[i]; frames[i]++;
                end else begin
                    flen[i]++;
                end
                if (busy[i]) gap[i] = 0; else gap[i]++;
                if (seg_clk[i] && !prev_clk[i]) begin
                    cap[i] = {cap[i][62:0], seg_sout[i]};
                    rises[i]++;
                end
                if (seg_latch[i]) latch_len[i]++;
                if (busy[i] && seg_sout[i]) ones[i]++;
                if (done[i]) begin
                    done_len[i] = flen[i];
                    dones[i]++;
                end
                prev_busy[i] = busy[i];
                prev_clk[i]  = seg_clk[i];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int i);
        start[i] = 1'b1;
        step(1);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int bound, input string name);
        int d0, n;
        d0 = dones[i];
        n  = 0;
        while (dones[i] == d0 && n < bound) begin
            step(1);
            n++;
        end
        chk({name, "_done_seen"}, 64'(dones[i] != d0), 64'h1);
    endtask

    initial begin
        int f0, dn, n;
        start[0] = 1'b0; start[1] = 1'b0;
        disp[0]  = 64'h0; disp[1] = 64'h0;
        rst = 1'b1;
        step(3);
        chk("reset_clrn", 64'(seg_clrn[0]), 64'h0);
        chk("reset_busy", 64'(busy[0]), 64'h0);
        rst = 1'b0;
        step(2);
        $display("txn reset released");

        // Single frame, default DIV.
        disp[0] = 64'hA5A5_0000_FFFF_1234;
        pulse(0);
        wait_done(0, 400, "frame1");
        chk("frame1_data", cap[0], 64'hA5A5_0000_FFFF_1234);
        chk("frame1_rises", 64'(rises[0]), 64'd64);
        chk("frame1_latch_len", 64'(latch_len[0]), 64'd2);
        chk("frame1_done_len", 64'(done_len[0]), 64'd258);
        step(1);
        chk("frame1_done_one_cycle", 64'(done[0]), 64'h0);
        $display("txn frame data=%h len=%0d", cap[0], done_len[0]);

        // Image change after the load edge must not leak into the frame.
        step(3);
        disp[0] = 64'h0;
        pulse(0);
        step(20);
        disp[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_done(0, 400, "stable");
        chk("stable_data", cap[0], 64'h0);
        chk("stable_ones", 64'(ones[0]), 64'h0);
        $display("txn data-stability frame data=%h", cap[0]);

        // Requests while busy collapse into exactly one extra frame.
        step(3);
        f0 = frames[0];
        disp[0] = 64'hDEAD_BEEF_0123_4567;
        pulse(0);
        step(10);  pulse(0);
        step(40);  pulse(0);
        step(40);  pulse(0);
        step(50);
        disp[0] = 64'h1;
        wait_done(0, 400, "busy_f1");
        chk("busy_f1_data", cap[0], 64'hDEAD_BEEF_0123_4567);
        wait_done(0, 400, "busy_f2");
        chk("busy_f2_data", cap[0], 64'h1);
        chk("busy_f2_gap", 64'(last_gap[0]), 64'd1);
        step(300);
        chk("busy_frames", 64'(frames[0] - f0), 64'd2);
        $display("txn pending frame data=%h gap=%0d", cap[0], last_gap[0]);

        // Reset in the middle of a frame.
        disp[0] = 64'h0F0F_3C3C_5A5A_9669;
        pulse(0);
        step(120);
        dn = dones[0];
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_clk", 64'(seg_clk[0]), 64'h0);
        chk("midrst_latch", 64'(seg_latch[0]), 64'h0);
        chk("midrst_busy", 64'(busy[0]), 64'h0);
        chk("midrst_clrn", 64'(seg_clrn[0]), 64'h0);
        step(300);
        chk("midrst_no_done", 64'(dones[0]), 64'(dn));
        pulse(0);
        wait_done(0, 400, "after_rst");
        chk("after_rst_data", cap[0], 64'h0F0F_3C3C_5A5A_9669);
        chk("after_rst_rises", 64'(rises[0]), 64'd64);
        $display("txn post-reset frame data=%h", cap[0]);

        // DIV=1 instance.
        disp[1] = 64'h8000_0000_0000_0001;
        pulse(1);
        wait_done(1, 300, "div1");
        chk("div1_data", cap[1], 64'h8000_0000_0000_0001);
        chk("div1_rises", 64'(rises[1]), 64'd64);
        chk("div1_done_len", 64'(done_len[1]), 64'd129);
        chk("div1_latch_len", 64'(latch_len[1]), 64'd1);
        $display("txn div1 frame data=%h len=%0d", cap[1], done_len[1]);

        // Start coincident with done.
        step(3);
        disp[0] = 64'h1234_5678_9ABC_DEF0;
        pulse(0);
        n = 0;
        while (!done[0] && n < 400) begin
            step(1);
            n++;
        end
        chk("ondone_seen", 64'(done[0]), 64'h1);
        disp[0]  = 64'hFEDC_BA98_7654_3210;
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        chk("ondone_busy", 64'(busy[0]), 64'h1);
        wait_done(0, 400, "ondone");
        chk("ondone_data", cap[0], 64'hFEDC_BA98_7654_3210);
        chk("ondone_gap", 64'(last_gap[0]), 64'd1);
        $display("txn start-on-done frame data=%h gap=%0d", cap[0], last_gap[0]);

        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
